conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Parametrised 3x3 streaming convolution for the camera video pipeline. Successor to the fixed 20x20 edge filter.
- Input: packed multi-channel pixel stream in raster order. Output: one filtered pixel per accepted input pixel.
- Adds programmable kernel, configurable image size, channel count and width, border masking, saturation, and full valid/ready backpressure.
- Sits between the pixel source and the display/colour stages on dstream interfaces.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- CH, 3, number of channels per pixel
- CW, 10, bits per channel (unsigned)
- COEF_W, 8, coefficient width (signed two's complement)
- SHIFT, 0, arithmetic right shift applied to each channel sum before clamping

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- x.data  in  CH*CW  input pixel; channel c at bits [c*CW +: CW]
- x.valid  in  1  input sample valid
- x.ready  out  1  block accepts input this cycle
- y.data  out  CH*CW  output pixel, same packing as x.data
- y.valid  out  1  output valid
- y.ready  in  1  downstream accepts output
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major; 0 = top-left (oldest), 8 = bottom-right (newest)
- coef_wdata  in  COEF_W  coefficient value

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - y.valid=0, y.data=0, pipeline valid bits=0, col/row counters=0.
  - Kernel = Laplacian: all -1, index 4 = +8.
  - x.ready=0 while reset is high.
- Handshake:
  - advance = !y.valid | y.ready; x.ready = advance & !reset.
  - An input is accepted when x.valid & x.ready.
  - All pipeline stages move only on advance.
  - y.data and y.valid hold stable while y.valid & !y.ready.
  - A bubble (x.valid=0) propagates as an invalid stage; nothing is dropped or duplicated.
- Latency: 2 cycles from accepted input to y.valid with no stall.
  - Stage 1: window capture and multiply.
  - Stage 2: sum, shift, clamp, output register.
- Window storage:
  - Two line buffers of IMG_W-1 pixels plus a 3x3 window register; all shift on accept only.
  - Line buffers are never cleared; border masking covers stale data.
- Position tracking:
  - col and row count the accepted pixel.
  - col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0, which is the frame restart.
- Output alignment:
  - The output for accepted pixel (r,c) is the window centred at (r-1,c-1), so the output image is offset by (1,1).
  - If r<2 or c<2, the output is 0 for all channels (border or invalid window).
- Arithmetic, per channel:
  - Product = unsigned pixel * signed coefficient.
  - Sum of 9 products, width CW+COEF_W+5, no internal overflow.
  - Arithmetic shift right by SHIFT.
  - Clamp: <0 -> 0, >2^CW-1 -> 2^CW-1.
- Coefficient writes:
  - A write takes effect from the next accepted pixel.
  - coef_addr > 8 is ignored.
  - A write in the same cycle as an accept does not affect that pixel.
  - Writes are legal during stalls.
- Reset mid-frame: pipeline is flushed, in-flight outputs are discarded, counters return to 0, and the next pixel is treated as (0,0). The kernel also resets to default.

Optional Feature:
- Macro CONV3X3_OVERFLOW_EN.
- When defined:
  - Adds output port `overflow` (1 bit, reset 0).
  - Sticky: set when any channel of an output clamps on the high or low side.
  - Cleared on reset and on the first accepted pixel of each frame (row=0, col=0).
- When undefined: no port and no logic; the clamp behaviour is unchanged.

Test Plan (all scenarios use IMG_W=8, IMG_H=6, CH=3, CW=10, SHIFT=0):
- Constant frame: all channels 100, default kernel -> all 48 outputs are 0, with exactly 48 y.valid beats.
- Impulse at (3,3) in a zero frame:
  - Stimulus: all channels 50 at (3,3); default kernel.
  - Output for input (4,4) = 400 on each channel.
  - Outputs for the 8 neighbours clamp to 0; all other outputs are 0.
- Identity kernel (index 4 = 1, others 0) on a ramp frame (pixel k = k on each channel) -> for r,c>=2, output at input index k equals k-9; border outputs are 0.
- Saturation:
  - Kernel index 4 = 8, others 0; constant input 200 -> interior outputs are 1023.
  - With CONV3X3_OVERFLOW_EN, overflow rises at the first interior output and clears at the next frame start.
- Backpressure: ramp frame with y.ready patterns 1010…, then random 30% low, then x.valid gaps -> output sequence is identical to the no-stall run, and y.data is stable during every stall.
- Reset at accepted pixel 20:
  - y.valid is 0 the cycle after reset.
  - The kernel is back to the Laplacian.
  - A following clean frame matches the golden outputs exactly.

Source files
------------

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: 3x3 streaming convolution over a packed multi-channel
// raster pixel stream with valid/ready handshake on both sides.
//
//   Stage 1: window update and per-tap multiply (registered products)
//   Stage 2: 9-tap sum, arithmetic shift, clamp, output register
//
// The output for accepted pixel (r,c) is the window centred on (r-1,c-1);
// any output whose window touches row 0/1 or column 0/1 is forced to 0.
//
// Optional feature: define CONV3X3_OVERFLOW_EN to add a sticky `overflow`
// output that flags any clamped channel, cleared at each frame start.

module conv3x3_stream #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int CH     = 3,
    parameter int CW     = 10,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH*CW-1:0]     x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic [CH*CW-1:0]     y_data,
    output logic                 y_valid,
    input  logic                 y_ready,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic [COEF_W-1:0]    coef_wdata
`ifdef CONV3X3_OVERFLOW_EN
    ,
    output logic                 overflow
`endif
);

    localparam int PW     = CH * CW;
    localparam int NTAP   = 9;
    localparam int PROD_W = CW + COEF_W + 1;
    localparam int SUM_W  = CW + COEF_W + 5;
    localparam int LB_LEN = IMG_W - 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Largest representable output channel value, widened to the sum width.
    localparam logic signed [SUM_W-1:0] PIX_MAX = {{(SUM_W - CW){1'b0}}, {CW{1'b1}}};

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Unsigned pixel times signed coefficient; both operands are widened
    // explicitly so the product is computed as a signed PROD_W-bit value.
    function automatic prod_t mul_tap(input logic [CW-1:0] pix,
                                      input logic signed [COEF_W-1:0] k);
        prod_t a;
        prod_t b;
        a = {{(PROD_W - CW){1'b0}}, pix};
        b = {{(PROD_W - COEF_W){k[COEF_W-1]}}, k};
        return a * b;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic advance;
    logic accept;

    assign advance = !y_valid || y_ready;
    assign x_ready = advance && !reset;
    assign accept  = x_valid && x_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Window is row-major: 0 = top-left (oldest), 8 = bottom-right (newest).
    logic [PW-1:0]            win      [NTAP];
    logic [PW-1:0]            win_next [NTAP];
    logic [PW-1:0]            lb1      [LB_LEN];
    logic [PW-1:0]            lb2      [LB_LEN];
    logic signed [COEF_W-1:0] coef     [NTAP];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    prod_t prod   [CH][NTAP];
    prod_t prod_r [CH][NTAP];
    logic  s1_valid;
    logic  s1_border;

    sum_t          sum_c [CH];
    sum_t          shf   [CH];
    logic [PW-1:0] y_next;

    // Window contents after the current accept: bottom row takes the new
    // pixel, the middle and top rows are fed by the two line buffers.
    always_comb begin
        win_next[8] = x_data;
        win_next[7] = win[8];
        win_next[6] = win[7];
        win_next[5] = lb1[LB_LEN-1];
        win_next[4] = win[5];
        win_next[3] = win[4];
        win_next[2] = lb2[LB_LEN-1];
        win_next[1] = win[2];
        win_next[0] = win[1];
    end

    // Per-channel, per-tap products of the updated window.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int t = 0; t < NTAP; t++) begin
                prod[c][t] = mul_tap(win_next[t][c*CW +: CW], coef[t]);
            end
        end
    end

    // Window and line buffers shift on accept only.
    // NOTE: these arrays are deliberately left unreset; border masking hides
    // stale contents, and a reset on wide storage only costs routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int t = 0; t < NTAP; t++) begin
                win[t] <= win_next[t];
            end
            // lb1 is fed from the previous newest pixel so that its tail is
            // exactly one line behind the incoming pixel; lb2 likewise
            // trails lb1's output by one line.
            lb1[0] <= win[8];
            lb2[0] <= win[5];
            for (int i = 1; i < LB_LEN; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficients
    // ------------------------------------------------------------------
    // Kernel register: Laplacian on reset, out-of-range addresses ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NTAP; t++) begin
                coef[t] <= (t == 4) ? COEF_W'(8) : {COEF_W{1'b1}};
            end
        end else if (coef_we && (coef_addr < 4'(NTAP))) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    // Column/row of the pixel being accepted; row wrap is the frame restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    // Stage-1 valid bit moves with the pipeline; a bubble enters as 0.
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
        end
    end

    // Stage-1 datapath: products and border flag captured with the pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CH; c++) begin
                for (int t = 0; t < NTAP; t++) begin
                    prod_r[c][t] <= prod[c][t];
                end
            end
            s1_border <= (row < ROW_TWO) || (col < COL_TWO);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    // Sum of nine products, arithmetic shift, clamp to [0, 2^CW-1].
    // NOTE: every output of this block gets a value on every path (defaults
    // first), so no latch is inferred.
    always_comb begin
        y_next = '0;
        for (int c = 0; c < CH; c++) begin
            sum_c[c] = '0;
            for (int t = 0; t < NTAP; t++) begin
                sum_c[c] = sum_c[c] + sum_t'(prod_r[c][t]);
            end
            shf[c] = sum_c[c] >>> SHIFT;
            if (shf[c][SUM_W-1]) begin
                y_next[c*CW +: CW] = '0;
            end else if (shf[c] > PIX_MAX) begin
                y_next[c*CW +: CW] = '1;
            end else begin
                y_next[c*CW +: CW] = shf[c][CW-1:0];
            end
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (advance) begin
            y_valid <= s1_valid;
            if (s1_valid) begin
                y_data <= s1_border ? '0 : y_next;
            end
        end
    end

`ifdef CONV3X3_OVERFLOW_EN
    logic clip_any;

    // Any channel of the stage-2 result hitting either clamp rail.
    always_comb begin
        clip_any = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (shf[c][SUM_W-1] || (shf[c] > PIX_MAX)) begin
                clip_any = 1'b1;
            end
        end
    end

    // Sticky clamp flag; the first pixel of a frame clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (accept && (row == '0) && (col == '0)) begin
            overflow <= 1'b0;
        end else if (advance && s1_valid && !s1_border && clip_any) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream on an 8x6 image, three
// 10-bit channels. Expected pixels come from a direct 2D convolution of the
// stimulus frame, plus a handful of hand-computed spot values.

module tb_conv3x3_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int CH = 3;
    localparam int CW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH*CW-1:0]  x_data;
    logic              x_valid;
    logic              x_ready;
    logic [CH*CW-1:0]  y_data;
    logic              y_valid;
    logic              y_ready;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [7:0]        coef_wdata;
`ifdef CONV3X3_OVERFLOW_EN
    logic              overflow;
`endif

    always #5 clk = ~clk;

    conv3x3_stream #(
        .IMG_W(W), .IMG_H(H), .CH(CH), .CW(CW), .COEF_W(8), .SHIFT(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
`ifdef CONV3X3_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    int total = 0;
    int bad   = 0;
    int kern [9];
    int cyc   = 0;

    logic [CH*CW-1:0] got   [$];
    logic [CH*CW-1:0] ref_q [$];
    int               acc_cyc  [$];
    int               beat_cyc [$];
    logic             stall_pending = 1'b0;
    logic [CH*CW-1:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stimulus patterns: 0 const 100, 1 impulse 50 at (3,3), 2 ramp k,
    // 3 const 200, 4 ramp with per-channel offset 37*c.
    function automatic logic [CW-1:0] pix(input int pat, input int k, input int c);
        case (pat)
            0:       return 10'd100;
            1:       return (k == 27) ? 10'd50 : 10'd0;
            2:       return CW'(k);
            3:       return 10'd200;
            default: return CW'(k + 37 * c);
        endcase
    endfunction

    function automatic logic [CH*CW-1:0] pixel(input int pat, input int k);
        logic [CH*CW-1:0] w;
        w = '0;
        for (int c = 0; c < CH; c++) w[c*CW +: CW] = pix(pat, k, c);
        return w;
    endfunction

    // Reference: direct convolution of the frame, window centred (r-1,c-1).
    function automatic int gold(input int pat, input int k, input int c);
        int r, cc, s;
        r  = k / W;
        cc = k % W;
        if (r < 2 || cc < 2) return 0;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(pix(pat, (r - 2 + i) * W + (cc - 2 + j), c)) * kern[i*3 + j];
        if (s < 0) return 0;
        if (s > 1023) return 1023;
        return s;
    endfunction

    function automatic logic rdy(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 2) == 0;
            default: return $urandom_range(0, 99) >= 30;
        endcase
    endfunction

    // One clock: drive at negedge, sample 1 time unit later.
    task automatic step(input logic xv, input logic [CH*CW-1:0] xd, input logic yr,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        output logic acc);
        @(negedge clk);
        x_valid = xv; x_data = xd; y_ready = yr;
        coef_we = we; coef_addr = wa; coef_wdata = wd;
        #1;
        cyc++;
        if (stall_pending) begin
            check("hold_valid", 32'(y_valid), 32'd1);
            check("hold_data", 32'(y_data), 32'(held));
        end
        acc = xv && x_ready;
        if (acc) acc_cyc.push_back(cyc);
        if (y_valid && y_ready) begin
            got.push_back(y_data);
            beat_cyc.push_back(cyc);
        end
        stall_pending = y_valid && !y_ready;
        held = y_data;
    endtask

    task automatic write_coef(input int a, input int v);
        logic acc;
        step(1'b0, '0, 1'b1, 1'b1, 4'(a), 8'(v), acc);
    endtask

    task automatic set_kernel(input int kv [9]);
        for (int i = 0; i < 9; i++) begin
            write_coef(i, kv[i]);
            kern[i] = kv[i];
        end
    endtask

    task automatic send_frame(input int pat, input int rmode, input bit gaps);
        logic acc;
        int   n;
        int   budget;
        got.delete(); acc_cyc.delete(); beat_cyc.delete();
        n = 0;
        for (int k = 0; k < N; k++) begin
            budget = 0;
            do begin
                step(gaps ? ($urandom_range(0, 99) < 70) : 1'b1, pixel(pat, k),
                     rdy(rmode, n), 1'b0, 4'd0, 8'd0, acc);
                n++; budget++;
            end while (!acc && budget < 200);
            if (!acc) begin
                check("accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
        budget = 0;
        while (got.size() < N && budget < 300) begin
            step(1'b0, '0, rdy(rmode, n), 1'b0, 4'd0, 8'd0, acc);
            n++; budget++;
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 4'd0, 8'd0, acc);
        check($sformatf("beats_p%0d", pat), 32'(got.size()), 32'(N));
    endtask

    task automatic compare_frame(input int pat, input bit vs_ref);
        logic [CH*CW-1:0] w;
        for (int k = 0; k < N && k < got.size(); k++) begin
            w = got[k];
            for (int c = 0; c < CH; c++)
                check($sformatf("p%0d_k%0d_c%0d", pat, k, c), 32'(w[c*CW +: CW]),
                      32'(gold(pat, k, c)));
            if (vs_ref && k < ref_q.size())
                check($sformatf("vs_nostall_k%0d", k), 32'(w), 32'(ref_q[k]));
        end
    endtask

    function automatic logic [CW-1:0] chan(input int k, input int c);
        logic [CH*CW-1:0] w;
        if (k >= got.size()) return '1;
        w = got[k];
        return w[c*CW +: CW];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        reset = 1'b1; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_x_ready", 32'(x_ready), 32'd0);
        check("reset_y_valid", 32'(y_valid), 32'd0);
        check("reset_y_data", 32'(y_data), 32'd0);
        reset = 1'b0;

        // Constant frame, default Laplacian: everything is 0
        send_frame(0, 0, 1'b0);
        compare_frame(0, 1'b0);
        if (got.size() > 0 && acc_cyc.size() > 0)
            check("latency", 32'(beat_cyc[0] - acc_cyc[0]), 32'd2);
        else
            check("latency_no_beat", 32'd0, 32'd1);

        // Impulse at (3,3) in a zero frame
        send_frame(1, 0, 1'b0);
        compare_frame(1, 1'b0);
        check("impulse_centre", 32'(chan(36, 0)), 32'd400);
        check("impulse_centre_c2", 32'(chan(36, 2)), 32'd400);
        check("impulse_neigh", 32'(chan(27, 1)), 32'd0);

        // Identity kernel on ramp; out-of-range writes must be ignored
        set_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        write_coef(9, 7);
        write_coef(12, 5);
        send_frame(2, 0, 1'b0);
        compare_frame(2, 1'b0);
        check("ident_k20", 32'(chan(20, 0)), 32'd11);
        check("ident_k47", 32'(chan(47, 1)), 32'd38);
        check("ident_border", 32'(chan(17, 0)), 32'd0);

        // Saturation: 8 * 200 clamps high
        write_coef(4, 8); kern[4] = 8;
        send_frame(3, 0, 1'b0);
        compare_frame(3, 1'b0);
        check("sat_k18", 32'(chan(18, 0)), 32'd1023);
        check("sat_border", 32'(chan(0, 0)), 32'd0);

        // Asymmetric kernel on channel-offset ramp, then with backpressure
        set_kernel('{-1, 0, 0, 0, 0, 0, 1, 0, 2});
        send_frame(4, 0, 1'b0);
        compare_frame(4, 1'b0);
        check("asym_k47_c0", 32'(chan(47, 0)), 32'd110);
        check("asym_k47_c1", 32'(chan(47, 1)), 32'd184);
        ref_q = got;
        send_frame(4, 1, 1'b0);
        compare_frame(4, 1'b1);
        send_frame(4, 2, 1'b0);
        compare_frame(4, 1'b1);
        send_frame(4, 2, 1'b1);
        compare_frame(4, 1'b1);

        // Reset after 20 accepted pixels with a non-default kernel loaded
        set_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        for (int k = 0; k < 20; k++) begin
            do step(1'b1, pixel(2, k), 1'b1, 1'b0, 4'd0, 8'd0, acc); while (!acc);
        end
        @(negedge clk);
        reset = 1'b1; x_valid = 1'b0; y_ready = 1'b1; #1;
        check("midrst_x_ready", 32'(x_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_y_valid", 32'(y_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall_pending = 1'b0;
        kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        send_frame(1, 0, 1'b0);
        compare_frame(1, 1'b0);
        check("midrst_laplacian", 32'(chan(36, 1)), 32'd400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
